// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 16;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_ADDR_SHIFT = 2;
    localparam int DEF_WAIT       = 2;
    localparam int INDEX_W        = $clog2(DEF_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_ST = 2'd1,
        RESP    = 2'd2
    } state_t;
endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between CPU and memory slave.
// Latency: n/a (wiring only).
// Backpressure: req_ready gates requests, resp_ready gates responses.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_write;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_write, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_write, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge, read is same-cycle.
// Backpressure: none; the caller decides when to write.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately never reset; only the access edge writes.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave: accepts one lw/sw, waits WAIT cycles, then accesses.
// Latency: response valid WAIT+1 edges after the accept edge.
// Backpressure: response held until resp_ready; no new request accepted until back in IDLE.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_SHIFT = DEF_ADDR_SHIFT,
    parameter int WAIT       = DEF_WAIT
) (
    input  logic             clock,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int IW    = $clog2(DEPTH);
    localparam int CNT_W = (WAIT < 2) ? 1 : $clog2(WAIT + 1);
    // One extra bit so DEPTH equal to the full address space still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic              lat_oor;
    logic [IW-1:0]     lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic              resp_valid_q;
    logic              resp_write_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] word_addr;
    logic              access;
    logic              mem_we;

    assign word_addr = bus.req_addr >> ADDR_SHIFT;
    assign access    = (state == WAIT_ST) && (cnt == '0);
    // Out-of-range stores never reach the array.
    assign mem_we    = access && lat_write && !lat_oor;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clock (clock),
        .we    (mem_we),
        .waddr (lat_idx),
        .wdata (lat_wdata),
        .raddr (lat_idx),
        .rdata (rd_data)
    );

    // Request latch, wait-state countdown, access and response handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            lat_write    <= 1'b0;
            lat_oor      <= 1'b0;
            lat_idx      <= '0;
            lat_wdata    <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_write <= bus.req_write;
                        lat_idx   <= word_addr[IW-1:0];
                        lat_oor   <= ({1'b0, word_addr} >= DEPTH_V);
                        lat_wdata <= bus.req_wdata;
                        cnt       <= CNT_W'(WAIT);
                        state     <= WAIT_ST;
                    end
                end
                WAIT_ST: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_write_q <= lat_write;
                        resp_err_q   <= lat_oor;
                        resp_rdata_q <= (lat_write || lat_oor) ? '0 : rd_data;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_write = resp_write_q;
    assign bus.resp_err   = resp_err_q;
endmodule
